chebyshev_requantizer: RTL and testbench
========================================

# chebyshev_requantizer

Pipelined, handshaked requantization stage for the Chebyshev datapath. It narrows a signed fixed-point word by discarding surplus integer bits (with saturation) and surplus fractional bits (with selectable rounding). Saturation events are reported per sample and accumulated in a clearable event counter. It sits between the Chebyshev recursion accumulator and the next coefficient multiplier, replacing the combinational saturate-only stage with a flow-controlled one.

## Interface
- WL, 16: input word length, two's complement
- I_BITS, 8: input integer bits, including sign; F = WL-I_BITS fractional bits
- BOUNDARY_BIT_POSITION, 4: integer bits kept at the output, including sign; legal range 2..I_BITS
- DROP_BITS, 4: fractional LSBs removed; legal range 1..F
- CNT_WL, 16: saturation counter width
- Derived: O_BITS = BOUNDARY_BIT_POSITION + F - DROP_BITS

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  WL  input sample
- in_valid  in  1  input sample present
- in_ready  out  1  stage can accept a sample
- round_mode  in  2  0 = truncate (floor), 1 = round half up, 2 = convergent (half to even), 3 = treated as 0
- out_data  out  O_BITS  requantized sample
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts
- sat_pos / sat_neg  out  1 each  qualify out_data; the sample was clipped high / low
- sat_count  out  CNT_WL  saturating count of clipped output transfers
- sat_sticky  out  1  set by any clipped output transfer
- stat_clear  in  1  synchronous clear of sat_count and sat_sticky

## Operation
- Input accepted when in_valid && in_ready. round_mode is captured with the sample and travels with it; a mode change affects only samples accepted later.
- Stage 1 (round):
  - Sign-extend to WL+1 bits; let r = value >>> DROP_BITS.
  - Mode 1: add 1 if bit DROP_BITS-1 is set.
  - Mode 2: add 1 if bit DROP_BITS-1 is set and any lower dropped bit is set; if only the half bit is set, add 1 only when r is odd.
  - Mode 0: r unchanged.
  - Result is held at WL+1-DROP_BITS bits, so no wrap can occur.
- Stage 2 (saturate):
  - Representable range is [-2^(O_BITS-1), 2^(O_BITS-1)-1] in output LSBs.
  - Above range: out_data = 0 followed by all ones, sat_pos=1.
  - Below range: out_data = 1 followed by all zeros, sat_neg=1.
  - Otherwise: low O_BITS of the rounded value, both flags 0.
  - Overflow caused by rounding up is saturated the same way.
- Flow control, per-stage valid:
  - s2_adv = !v2 || out_ready
  - s1_adv = !v1 || s2_adv
  - in_ready = s1_adv, combinational, no dependence on in_valid.
  - Bubbles collapse, so throughput is 1 sample/clk when out_ready is held high.
- Output stability: out_data and the sat flags hold stable while out_valid && !out_ready. Sample order is preserved and no samples are dropped or duplicated.
- Counter:
  - Increments on each output transfer (out_valid && out_ready) with sat_pos or sat_neg set.
  - Holds at all-ones and does not wrap.
  - sat_sticky sets on the same event.
- stat_clear in the same cycle as a clipped transfer: count loads 1 and sticky stays 1. stat_clear alone gives 0 / 0.

## Timing
- Latency: 2 clk from acceptance to out_valid, with no stall.
- Capacity: 2 samples in flight. With out_ready low, in_ready drops after the second sample accepted.
- Reset values: v1 = v2 = 0, out_valid=0, out_data=0, sat_pos=sat_neg=0, sat_count=0, sat_sticky=0. in_ready=1 while rst is high and after release.
- Reset mid-operation discards in-flight samples immediately (asynchronous); nothing is emitted after release until new input arrives.
- sat_count / sat_sticky update on the edge of the qualifying transfer and are visible the next cycle.

## Test plan
Defaults apply (Q8.8 in, Q4.4 out, O_BITS=8).
- Pass-through: in 0x0280 (2.5), mode 0, out_ready=1 -> out_data 0x28 two cycles later; flags 0; count unchanged.
- Clipping: in 0x0A00 (10.0) -> 0x7F, sat_pos; in 0xF600 (-10.0) -> 0x80, sat_neg; sat_count=2, sat_sticky=1.
- Rounding:
  - in 0x0118: mode 0 -> 0x11, mode 1 -> 0x12, mode 2 -> 0x12.
  - in 0x0128: mode 1 -> 0x13, mode 2 -> 0x12.
  - in 0x0119: mode 2 -> 0x12.
- Rounding overflow: in 0x07F8, mode 1 -> 0x7F with sat_pos=1; mode 0 -> 0x7F with sat_pos=0.
- Backpressure: stream 0x0100, 0x0200, 0x0300 with out_ready low for 5 cycles.
  - in_ready falls after 0x0100 and 0x0200 are accepted.
  - out_data holds 0x10 throughout the stall.
  - On release: outputs 0x10, 0x20, 0x30 in order, then throughput returns to 1/clk.
- Counter and reset: with CNT_WL=2, 5 clipped transfers -> sat_count=3 (held).
  - stat_clear coincident with a clipped transfer -> sat_count=1.
  - rst asserted with 2 samples in flight -> out_valid=0 immediately, and no output after release.

Source files
------------

// File: rtl/chebyshev_requantizer.sv
// chebyshev_requantizer
// Two-stage, flow-controlled requantizer for the Chebyshev datapath.
// Narrows a signed WL-bit word (I_BITS integer bits incl. sign) by dropping
// DROP_BITS fractional LSBs with selectable rounding, then clipping to
// BOUNDARY_BIT_POSITION integer bits. Clipped transfers are counted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid/in_ready     input sample handshake
//   round_mode          0 floor, 1 half up, 2 half to even, 3 floor
//   out_data/out_valid/out_ready  output sample handshake (O_BITS wide)
//   sat_pos/sat_neg     output sample was clipped high / low
//   sat_count           saturating count of clipped output transfers
//   sat_sticky          set by any clipped output transfer
//   stat_clear          synchronous clear of sat_count and sat_sticky
module chebyshev_requantizer #(
  parameter int WL                    = 16,
  parameter int I_BITS                = 8,
  parameter int BOUNDARY_BIT_POSITION = 4,
  parameter int DROP_BITS             = 4,
  parameter int CNT_WL                = 16,
  localparam int O_BITS = BOUNDARY_BIT_POSITION + WL - I_BITS - DROP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WL-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        round_mode,
  output logic [O_BITS-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_pos,
  output logic              sat_neg,
  output logic [CNT_WL-1:0] sat_count,
  output logic              sat_sticky,
  input  logic              stat_clear
);

  // Rounded value keeps one extra MSB over the shifted input so that a
  // round-up of the largest positive value cannot wrap.
  localparam int RW = WL + 1 - DROP_BITS;
  localparam int HW = RW - O_BITS + 1;

  function automatic logic signed [RW-1:0] round_fn(
    input logic signed [WL-1:0] x,
    input logic [1:0]           mode
  );
    logic signed [WL:0]   ext;
    logic signed [RW-1:0] r;
    logic                 half;
    logic                 rest;
    logic                 inc;
    ext  = {x[WL-1], x};
    r    = ext[WL:DROP_BITS];
    half = x[DROP_BITS-1];
    rest = 1'b0;
    for (int i = 0; i < DROP_BITS - 1; i++) rest = rest | x[i];
    case (mode)
      2'd1:    inc = half;
      2'd2:    inc = half && (rest || r[0]);
      default: inc = 1'b0;
    endcase
    return r + {{(RW-1){1'b0}}, inc};
  endfunction

  // Returns {pos, neg, data}. The value fits only if every bit from the
  // output sign position upward matches the MSB.
  function automatic logic [O_BITS+1:0] sat_fn(input logic signed [RW-1:0] r);
    logic [HW-1:0]     hi;
    logic              pos;
    logic              neg;
    logic [O_BITS-1:0] d;
    hi  = r[RW-1:O_BITS-1];
    pos = !r[RW-1] && (|hi);
    neg = r[RW-1] && !(&hi);
    if (pos)      d = {1'b0, {(O_BITS-1){1'b1}}};
    else if (neg) d = {1'b1, {(O_BITS-1){1'b0}}};
    else          d = r[O_BITS-1:0];
    return {pos, neg, d};
  endfunction

  logic                 vld_p1;
  logic signed [RW-1:0] rnd_p1;
  logic                 vld_p2;
  logic                 s1_adv;
  logic                 s2_adv;
  logic [O_BITS+1:0]    sat_p1;
  logic                 clip_xfer;

  assign s2_adv    = !vld_p2 || out_ready;
  assign s1_adv    = !vld_p1 || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_p2;
  assign sat_p1    = sat_fn(rnd_p1);
  assign clip_xfer = vld_p2 && out_ready && (sat_pos || sat_neg);

  // ---- stage 1: round (mode is applied at acceptance, so it travels with the sample)
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) rnd_p1 <= round_fn($signed(in_data), round_mode);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid;
  end

  // ---- stage 2: saturate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      out_data <= '0;
      sat_pos  <= 1'b0;
      sat_neg  <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        {sat_pos, sat_neg, out_data} <= sat_p1;
      end
    end
  end

  // ---- statistics: counted on the clipped output transfer itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count  <= '0;
      sat_sticky <= 1'b0;
    end else if (stat_clear) begin
      sat_count  <= clip_xfer ? CNT_WL'(1) : '0;
      sat_sticky <= clip_xfer;
    end else if (clip_xfer) begin
      if (!(&sat_count)) sat_count <= sat_count + CNT_WL'(1);
      sat_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chebyshev_requantizer.sv
module tb_chebyshev_requantizer;

  localparam int DROP = 4;
  localparam int OB   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    round_mode;
  logic [OB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sat_pos;
  logic          sat_neg;
  logic [CW-1:0] sat_count;
  logic          sat_sticky;
  logic          stat_clear;

  chebyshev_requantizer #(
    .WL(16), .I_BITS(8), .BOUNDARY_BIT_POSITION(4), .DROP_BITS(DROP), .CNT_WL(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .round_mode(round_mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_pos(sat_pos), .sat_neg(sat_neg),
    .sat_count(sat_count), .sat_sticky(sat_sticky),
    .stat_clear(stat_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OB-1:0] d;
    logic          p;
    logic          n;
  } exp_t;

  exp_t    q[$];
  int      checks = 0;
  int      errors = 0;
  int      exp_cnt = 0;
  logic    exp_sticky = 1'b0;
  logic    prev_hold = 1'b0;
  logic [OB-1:0] held_d;
  logic    held_p, held_n;

  // Reference: real-valued requantization using integer floor division.
  function automatic exp_t model(input logic [15:0] d, input logic [1:0] m);
    exp_t e;
    int v, rem, qv, step, maxv;
    step = 1 << DROP;
    maxv = (1 << (OB - 1)) - 1;
    v    = int'($signed(d));
    rem  = ((v % step) + step) % step;
    qv   = (v - rem) / step;
    if (m == 2'd1 && 2 * rem >= step) qv = qv + 1;
    if (m == 2'd2 && (2 * rem > step || (2 * rem == step && (qv % 2) != 0))) qv = qv + 1;
    e.p = 1'b0;
    e.n = 1'b0;
    if (qv > maxv) begin
      e.d = OB'(maxv);
      e.p = 1'b1;
    end else if (qv < -maxv - 1) begin
      e.d = OB'(-maxv - 1);
      e.n = 1'b1;
    end else begin
      e.d = OB'(qv);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // let the rising edge happen and return at the next falling edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic [1:0] m,
                     input logic ordy, input logic clr);
    exp_t e;
    logic clip;
    in_valid   = v;
    in_data    = d;
    round_mode = m;
    out_ready  = ordy;
    stat_clear = clr;
    #1;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held_d);
      chk("hold_flags", {sat_pos, sat_neg}, {held_p, held_n});
    end
    chk("sat_count", sat_count, exp_cnt);
    chk("sat_sticky", sat_sticky, exp_sticky);
    clip = 1'b0;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_flags", {sat_pos, sat_neg}, {e.p, e.n});
        clip = e.p || e.n;
      end
    end
    if (in_valid && in_ready) q.push_back(model(d, m));
    if (clr) begin
      exp_cnt    = clip ? 1 : 0;
      exp_sticky = clip;
    end else if (clip) begin
      if (exp_cnt < CMAX) exp_cnt++;
      exp_sticky = 1'b1;
    end
    prev_hold = out_valid && !out_ready;
    held_d = out_data;
    held_p = sat_pos;
    held_n = sat_neg;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 2'd0, ordy, 1'b0);
  endtask

  // Send one sample through an idle pipeline with out_ready high.
  task automatic one(input logic [15:0] d, input logic [1:0] m);
    cyc(1'b1, d, m, 1'b1, 1'b0);
    idle(2, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; round_mode = '0; out_ready = 1'b0; stat_clear = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {sat_pos, sat_neg}, 0);
    chk("rst_count", sat_count, 0);
    chk("rst_sticky", sat_sticky, 0);
    rst = 1'b0;

    // Pass-through and two-cycle latency
    cyc(1'b1, 16'h0280, 2'd0, 1'b1, 1'b0);
    chk("lat_not1", out_valid, 0);
    idle(1, 1'b1);
    chk("lat_2_valid", out_valid, 1);
    chk("pass_data", out_data, 8'h28);
    idle(1, 1'b1);

    // Clipping
    one(16'h0A00, 2'd0);
    one(16'hF600, 2'd0);
    chk("clip_count2", sat_count, 2);
    chk("clip_sticky", sat_sticky, 1);

    // Rounding modes
    one(16'h0118, 2'd0);
    one(16'h0118, 2'd1);
    one(16'h0118, 2'd2);
    one(16'h0128, 2'd1);
    one(16'h0128, 2'd2);
    one(16'h0119, 2'd2);
    one(16'h0118, 2'd3);

    // Rounding overflow (mode 0 first, so count stays 2 until the mode-1 case)
    one(16'h07F8, 2'd0);
    chk("rovf_m0_count", sat_count, 2);
    one(16'h07F8, 2'd1);
    chk("rovf_m1_count", sat_count, 3);

    // Counter holds at all-ones
    one(16'h0A00, 2'd0);
    one(16'hF600, 2'd0);
    chk("cnt_held", sat_count, 3);

    // stat_clear coincident with a clipped transfer, then alone
    cyc(1'b1, 16'h0A00, 2'd0, 1'b1, 1'b0);
    idle(1, 1'b1);
    cyc(1'b0, 16'h0000, 2'd0, 1'b1, 1'b1);
    chk("clr_coinc_count", sat_count, 1);
    chk("clr_coinc_sticky", sat_sticky, 1);
    cyc(1'b0, 16'h0000, 2'd0, 1'b1, 1'b1);
    chk("clr_alone_count", sat_count, 0);
    chk("clr_alone_sticky", sat_sticky, 0);

    // Backpressure
    cyc(1'b1, 16'h0100, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0200, 2'd0, 1'b0, 1'b0);
    chk("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0300, 2'd0, 1'b0, 1'b0);
    chk("bp_hold_data", out_data, 8'h10);
    cyc(1'b1, 16'h0300, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("tput_in_ready", in_ready, 1);
      chk("tput_out_valid", out_valid, 1);
      cyc(1'b1, 16'((i + 4) << 8), 2'd0, 1'b1, 1'b0);
    end
    idle(3, 1'b1);
    chk("drain1_empty", q.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 30) == 0));
    end
    idle(4, 1'b1);
    chk("drain2_empty", q.size(), 0);

    // Asynchronous reset with two samples in flight
    cyc(1'b1, 16'h0A00, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0200, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_count", sat_count, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    exp_sticky = 1'b0;
    prev_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
      chk("post_rst_no_out", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
